// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared FSM state type and counter sizing for the sequential divider
//
// Purpose: types and constants shared by seq_divider_regs and div_step.
// Contents:
//   div_state_e    - FSM states IDLE / RUN / DONE
//   SEQ_DIV_N      - default operand width
//   SEQ_DIV_CNT_W  - iteration counter width for the default operand width
//   cnt_width(n)   - iteration counter width for an n-bit divider, $clog2(n+1)
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int SEQ_DIV_N     = 32;
  localparam int SEQ_DIV_CNT_W = $clog2(SEQ_DIV_N + 1);

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - combinational one-bit restoring division step
//
// Purpose: one restoring-division iteration. Shifts the next dividend bit into
// the partial remainder, trial-subtracts the divisor and shifts the resulting
// quotient bit into the dividend/quotient register.
// Ports:
//   rem_in   [N-1:0] - current partial remainder
//   quo_in   [N-1:0] - remaining dividend bits (MSB next) / quotient bits so far
//   divisor  [N-1:0] - divisor magnitude
//   rem_out  [N-1:0] - next partial remainder
//   quo_out  [N-1:0] - next dividend/quotient register value
module div_step
  import seq_div_pkg::*;
#(
  parameter int N = SEQ_DIV_N
) (
  input  logic [N-1:0] rem_in,
  input  logic [N-1:0] quo_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_out,
  output logic [N-1:0] quo_out
);

  // The stored remainder is always below the divisor, so it fits in N bits.
  // After the shift it can reach 2*divisor-1, so the shift and trial subtract
  // are carried out N+1 bits wide; the top bit of the trial is then the borrow.
  logic [N:0] rem_shift;
  logic [N:0] trial;

  always_comb begin
    rem_shift = {rem_in, quo_in[N-1]};
    trial     = rem_shift - {1'b0, divisor};
    if (!trial[N]) begin
      rem_out = trial[N-1:0];
      quo_out = {quo_in[N-2:0], 1'b1};
    end else begin
      rem_out = rem_shift[N-1:0];
      quo_out = {quo_in[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider_regs.sv
// rtl/seq_divider_regs.sv - N-cycle restoring sequential divider with registered result
//
// Purpose: divides dividend by divisor over N+2 clock edges (capture, N steps,
// result load). Optional macro SEQ_DIV_SIGNED_EN selects two's-complement
// operation (quotient truncates toward zero, remainder takes dividend's sign);
// without it the divider is unsigned only.
// Ports:
//   clk               - clock, rising edge
//   reset             - synchronous active-low reset
//   en                - start request, sampled only in IDLE
//   dividend [N-1:0]  - numerator
//   divisor  [N-1:0]  - denominator
//   result [2N-1:0]   - registered {remainder, quotient}
//   valid             - one-cycle pulse with each new result
//   busy              - high from accepted start through the DONE cycle
//   div_zero          - registered divide-by-zero flag, loaded with result
module seq_divider_regs
  import seq_div_pkg::*;
#(
  parameter int N = SEQ_DIV_N
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [N-1:0]   dividend,
  input  logic [N-1:0]   divisor,
  output logic [2*N-1:0] result,
  output logic           valid,
  output logic           busy,
  output logic           div_zero
);

  localparam int CW = cnt_width(N);

  div_state_e     state_q, state_d;
  logic [N-1:0]   quo_q, quo_d;       // dividend register, becomes the quotient
  logic [N-1:0]   dvs_q, dvs_d;       // divisor register
  logic [N-1:0]   rem_q, rem_d;       // partial remainder
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] result_q, result_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           div_zero_q, div_zero_d;

  logic [N-1:0]   step_rem;
  logic [N-1:0]   step_quo;
  logic [N-1:0]   quo_fix;
  logic [N-1:0]   rem_fix;

`ifdef SEQ_DIV_SIGNED_EN
  logic           qneg_q, qneg_d;     // quotient must be negated at DONE
  logic           rneg_q, rneg_d;     // remainder must be negated at DONE
`endif

  div_step #(.N(N)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Sign fix-up of the magnitude result. A zero divisor needs no special
  // quotient handling in unsigned mode: every trial subtract succeeds, giving
  // all-ones, and the remainder accumulates the whole dividend.
  always_comb begin
    quo_fix = quo_q;
    rem_fix = rem_q;
`ifdef SEQ_DIV_SIGNED_EN
    if (dvs_q == '0) begin
      quo_fix = '1;
    end else if (qneg_q) begin
      quo_fix = ~quo_q + 1'b1;
    end
    // Negating |dividend| restores the dividend itself for a zero divisor.
    if (rneg_q) begin
      rem_fix = ~rem_q + 1'b1;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    div_zero_d = div_zero_q;
`ifdef SEQ_DIV_SIGNED_EN
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (en) begin
`ifdef SEQ_DIV_SIGNED_EN
          // Most-negative stays as its own bit pattern, which is the correct
          // unsigned magnitude 2^(N-1).
          quo_d  = dividend[N-1] ? (~dividend + 1'b1) : dividend;
          dvs_d  = divisor[N-1]  ? (~divisor + 1'b1)  : divisor;
          qneg_d = dividend[N-1] ^ divisor[N-1];
          rneg_d = dividend[N-1];
`else
          quo_d  = dividend;
          dvs_d  = divisor;
`endif
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        result_d   = {rem_fix, quo_fix};
        div_zero_d = (dvs_q == '0);
        valid_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      quo_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      div_zero_q <= div_zero_d;
`ifdef SEQ_DIV_SIGNED_EN
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
`endif
    end
  end

  assign result   = result_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign div_zero = div_zero_q;

endmodule
